// File: rtl/serijski_dekoder_parnosti_if.sv
// Serial parity-decoder bus: bit-serial input stream with ready/valid,
// parallel decoded word output with ready/valid, and the error-frame counter.
interface serijski_dekoder_parnosti_if #(
  parameter int N_PODATAKA = 40
);
  logic                  ulaz_bit;
  logic                  ulaz_pocetak;
  logic                  ulaz_valid;
  logic                  ulaz_ready;
  logic [N_PODATAKA-1:0] izlaz_podaci;
  logic                  izlaz_greska;
  logic                  izlaz_valid;
  logic                  izlaz_ready;
  logic [7:0]            broj_gresaka;

  modport master (
    output ulaz_bit, ulaz_pocetak, ulaz_valid, izlaz_ready,
    input  ulaz_ready, izlaz_podaci, izlaz_greska, izlaz_valid, broj_gresaka
  );

  modport slave (
    input  ulaz_bit, ulaz_pocetak, ulaz_valid, izlaz_ready,
    output ulaz_ready, izlaz_podaci, izlaz_greska, izlaz_valid, broj_gresaka
  );
endinterface

// File: rtl/serijski_dekoder_parnosti.sv
// Even-parity serial decoder: shifts in {parity, data} MSB first, presents the
// data word with an error flag, and counts erroneous frames (saturating).
module serijski_dekoder_parnosti #(
  parameter int N_PODATAKA = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serijski_dekoder_parnosti_if.slave  bus
);
  localparam int W     = N_PODATAKA + 1;
  localparam int CNT_W = $clog2(N_PODATAKA + 2);

  typedef enum logic [1:0] {
    MIRUJ  = 2'd0,
    PRIJEM = 2'd1,
    IZLAZ  = 2'd2
  } stanje_t;

  stanje_t               stanje_q, stanje_d;
  logic [N_PODATAKA-1:0] pomak_q, pomak_d;
  logic [W-1:0]          pomak_nov;
  logic [CNT_W-1:0]      brojac_q, brojac_d;
  logic [N_PODATAKA-1:0] podaci_q, podaci_d;
  logic                  greska_q, greska_d;
  logic [7:0]            broj_q, broj_d;
  logic                  prihvat;

  assign prihvat = bus.ulaz_valid && (stanje_q != IZLAZ);
  // The shift register only needs N bits: the final bit completes the word combinationally.
  assign pomak_nov = {pomak_q, bus.ulaz_bit};

  always_comb begin
    stanje_d = stanje_q;
    pomak_d  = pomak_q;
    brojac_d = brojac_q;
    podaci_d = podaci_q;
    greska_d = greska_q;
    broj_d   = broj_q;
    case (stanje_q)
      MIRUJ: begin
        if (prihvat && bus.ulaz_pocetak) begin
          pomak_d  = {{(N_PODATAKA-1){1'b0}}, bus.ulaz_bit};
          brojac_d = CNT_W'(1);
          stanje_d = PRIJEM;
        end
      end
      PRIJEM: begin
        if (prihvat) begin
          if (bus.ulaz_pocetak) begin
            pomak_d  = {{(N_PODATAKA-1){1'b0}}, bus.ulaz_bit};
            brojac_d = CNT_W'(1);
          end else if (brojac_q == CNT_W'(N_PODATAKA)) begin
            podaci_d = pomak_nov[N_PODATAKA-1:0];
            greska_d = ^pomak_nov;
            pomak_d  = '0;
            brojac_d = '0;
            stanje_d = IZLAZ;
          end else begin
            pomak_d  = pomak_nov[N_PODATAKA-1:0];
            brojac_d = brojac_q + CNT_W'(1);
          end
        end
      end
      IZLAZ: begin
        if (bus.izlaz_ready) begin
          stanje_d = MIRUJ;
          if (greska_q && (broj_q != 8'hFF)) begin
            broj_d = broj_q + 8'd1;
          end
        end
      end
      default: stanje_d = MIRUJ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje_q <= MIRUJ;
      pomak_q  <= '0;
      brojac_q <= '0;
      podaci_q <= '0;
      greska_q <= 1'b0;
      broj_q   <= 8'd0;
    end else begin
      stanje_q <= stanje_d;
      pomak_q  <= pomak_d;
      brojac_q <= brojac_d;
      podaci_q <= podaci_d;
      greska_q <= greska_d;
      broj_q   <= broj_d;
    end
  end

  assign bus.ulaz_ready   = (stanje_q != IZLAZ);
  assign bus.izlaz_valid  = (stanje_q == IZLAZ);
  assign bus.izlaz_podaci = podaci_q;
  assign bus.izlaz_greska = greska_q;
  assign bus.broj_gresaka = broj_q;
endmodule

// File: doc/serijski_dekoder_parnosti.md
SERIJSKI_DEKODER_PARNOSTI -- requirements
Module: serijski_dekoder_parnosti

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 The block SHALL have parameter N_PODATAKA, default 40, giving the data bits per codeword; each codeword is N_PODATAKA+1 bits.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ulaz_bit  in  1  serial codeword bit.
REQ-006 ulaz_pocetak  in  1  marks ulaz_bit as the first bit of a frame.
REQ-007 ulaz_valid  in  1  ulaz_bit/ulaz_pocetak are valid.
REQ-008 ulaz_ready  out  1  the block accepts a bit this cycle.
REQ-009 izlaz_podaci  out  N_PODATAKA  decoded data word.
REQ-010 izlaz_greska  out  1  parity error flag for izlaz_podaci.
REQ-011 izlaz_valid  out  1  izlaz_podaci/izlaz_greska are valid.
REQ-012 izlaz_ready  in  1  the sink accepts the output word.
REQ-013 broj_gresaka  out  8  saturating count of frames delivered with izlaz_greska=1.

Function
REQ-014 Codeword format SHALL be {parity, data[N_PODATAKA-1:0]}, even parity over all N_PODATAKA+1 bits, transmitted MSB first (parity bit first).
REQ-015 A bit SHALL be accepted only in a cycle where ulaz_valid=1 and ulaz_ready=1.
REQ-016 The FSM SHALL have states MIRUJ (idle), PRIJEM (receiving) and IZLAZ (output pending).
REQ-017 ulaz_ready SHALL be 1 in MIRUJ and PRIJEM and 0 in IZLAZ.
REQ-018 In MIRUJ, an accepted bit with ulaz_pocetak=1 SHALL become bit 1 of a new frame and move the FSM to PRIJEM; an accepted bit with ulaz_pocetak=0 SHALL be discarded.
REQ-019 In PRIJEM, each accepted bit SHALL be shifted in and a bit counter incremented; cycles without acceptance SHALL hold all state.
REQ-020 In PRIJEM, an accepted bit with ulaz_pocetak=1 SHALL abort the partial frame with no output and restart the frame with that bit as bit 1.
REQ-021 On acceptance of bit N_PODATAKA+1, the FSM SHALL enter IZLAZ.
REQ-022 On IZLAZ entry, izlaz_podaci SHALL be loaded with the low N_PODATAKA received bits, and izlaz_greska with the XOR of all N_PODATAKA+1 bits.
REQ-023 izlaz_valid SHALL be asserted in the cycle after the last bit is accepted (latency 1).
REQ-024 izlaz_valid, izlaz_podaci and izlaz_greska SHALL stay stable until izlaz_valid=1 and izlaz_ready=1 in the same cycle.
REQ-025 On that handshake, the FSM SHALL return to MIRUJ, with ulaz_ready=1 from the next cycle; there is no same-cycle bypass.
REQ-026 When a frame with izlaz_greska=1 completes its handshake, broj_gresaka SHALL increment, saturating at 255 with no wrap.
REQ-027 Data bits SHALL be passed through uncorrected even when izlaz_greska=1.
REQ-028 The bit counter SHALL be wide enough for N_PODATAKA+1 and SHALL never wrap within a frame.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in MIRUJ, and ulaz_ready=1, izlaz_valid=0, izlaz_greska=0, izlaz_podaci=0, broj_gresaka=0, with the shift register and counter cleared.
REQ-030 Reset asserted mid-frame or during IZLAZ SHALL discard the frame and pending output immediately, with no handshake.
REQ-031 After rst_n deasserts, the first frame SHALL require ulaz_pocetak.

Verification
REQ-032 N=40: send 41'h1646a6f6c65 MSB first, valid every cycle, pocetak on first bit, izlaz_ready=1 -> izlaz_valid one cycle after the last bit, izlaz_podaci=40'h646a6f6c65, izlaz_greska=0, broj_gresaka=0.
REQ-033 N=40: send 41'h1646a6f6c64 (LSB flipped) -> izlaz_podaci=40'h646a6f6c64, izlaz_greska=1, broj_gresaka=1 after the handshake.
REQ-034 N=12: send 13'h0648 -> izlaz_podaci=12'h648, izlaz_greska=0; with izlaz_ready held 0 for 10 cycles -> outputs stable, ulaz_ready=0 throughout.
REQ-035 Send 20 bits, then pocetak plus a full 41'h1646a6f6c65 -> exactly one output word (40'h646a6f6c65, greska 0).
REQ-036 Bits without pocetak while idle -> ignored, no output; reset asserted after 30 bits -> outputs return to reset values and the next correct frame decodes correctly.
REQ-037 Send 256 erroneous frames -> broj_gresaka=255, no wrap.
